ysyx_22050598_mem_arbiter: RTL

Two-master arbiter sharing the single 128-bit memory port between the instruction-cache refill path (IFU) and the data-cache refill/writeback path (LSU). It sits between the two caches and the external memory/bus bridge, registers the winning request, and sequences exactly one outstanding transaction at a time. It routes the one-cycle response pulse back to the owning cache. LSU has priority, with a starvation guard that guarantees IFU forward progress.

---
 rtl/ysyx_22050598_mem_arbiter_pkg.sv | 19 +
 rtl/ysyx_22050598_arb_starve_cnt.sv | 30 +++
 rtl/ysyx_22050598_mem_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/ysyx_22050598_mem_arbiter_pkg.sv
// rtl/ysyx_22050598_mem_arbiter_pkg.sv - shared state/owner encodings for the memory arbiter
package ysyx_22050598_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2,
      ST_DONE = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } arb_owner_e;

   // wide enough for STARVE_LIMIT up to 15
   localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/ysyx_22050598_arb_starve_cnt.sv
// rtl/ysyx_22050598_arb_starve_cnt.sv - saturating count of LSU wins while IFU waits
module ysyx_22050598_arb_starve_cnt
   import ysyx_22050598_mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic force_ifu
);

   localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

   logic [STARVE_CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != LIMIT)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign force_ifu = (cnt == LIMIT);

endmodule

// File: rtl/ysyx_22050598_mem_arbiter.sv
// rtl/ysyx_22050598_mem_arbiter.sv - IFU/LSU arbiter onto one 128-bit memory port, one transaction in flight
module ysyx_22050598_mem_arbiter
   import ysyx_22050598_mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int ADDR_W       = 64,
   parameter int LINE_W       = 128
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ifu_mem_valid,
   input  logic [ADDR_W-1:0]   ifu_mem_addr,
   output logic                ifu_mem_ready,
   output logic [LINE_W-1:0]   ifu_mem_data,
   input  logic                lsu_mem_valid,
   input  logic                lsu_mem_wen,
   input  logic [ADDR_W-1:0]   lsu_mem_addr,
   input  logic [LINE_W-1:0]   lsu_mem_wdata,
   input  logic [LINE_W/8-1:0] lsu_mem_wmask,
   output logic                lsu_mem_ready,
   output logic [LINE_W-1:0]   lsu_mem_data,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic                mem_req_wen,
   output logic [ADDR_W-1:0]   mem_req_addr,
   output logic [LINE_W-1:0]   mem_req_wdata,
   output logic [LINE_W/8-1:0] mem_req_wmask,
   input  logic                mem_resp_valid,
   input  logic [LINE_W-1:0]   mem_resp_data
);

   arb_state_e state, state_nxt;
   arb_owner_e owner;
   logic       grant;
   logic       pick_ifu;
   logic       force_ifu;
   logic       starve_inc;
   logic       starve_clr;
   logic       resp_take;

   // IFU wins only when alone or when LSU has starved it long enough
   assign pick_ifu   = ifu_mem_valid && (!lsu_mem_valid || force_ifu);
   assign grant      = (state == ST_IDLE) && (ifu_mem_valid || lsu_mem_valid);
   assign starve_inc = grant && !pick_ifu && ifu_mem_valid;
   assign starve_clr = (state == ST_IDLE) && (!ifu_mem_valid || pick_ifu);
   assign resp_take  = (state == ST_RESP) && mem_resp_valid;

   ysyx_22050598_arb_starve_cnt #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_starve (
      .clk      (clk),
      .rst      (rst),
      .inc      (starve_inc),
      .clr      (starve_clr),
      .force_ifu(force_ifu)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (grant)          state_nxt = ST_REQ;
         ST_REQ:  if (mem_req_ready)  state_nxt = ST_RESP;
         ST_RESP: if (mem_resp_valid) state_nxt = ST_DONE;
         ST_DONE:                     state_nxt = ST_IDLE;
         default:                     state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner         <= OWN_IFU;
         mem_req_wen   <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_wdata <= '0;
         mem_req_wmask <= '0;
      end else if (grant) begin
         owner         <= pick_ifu ? OWN_IFU : OWN_LSU;
         mem_req_wen   <= pick_ifu ? 1'b0 : lsu_mem_wen;
         mem_req_addr  <= pick_ifu ? ifu_mem_addr : lsu_mem_addr;
         mem_req_wdata <= pick_ifu ? '0 : lsu_mem_wdata;
         mem_req_wmask <= pick_ifu ? '0 : lsu_mem_wmask;
      end
   end

   // responses outside RESP are dropped; data holds between pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ifu_mem_data <= '0;
         lsu_mem_data <= '0;
      end else if (resp_take) begin
         if (owner == OWN_IFU) ifu_mem_data <= mem_resp_data;
         else                  lsu_mem_data <= mem_resp_data;
      end
   end

   assign mem_req_valid = (state == ST_REQ);
   assign ifu_mem_ready = (state == ST_DONE) && (owner == OWN_IFU);
   assign lsu_mem_ready = (state == ST_DONE) && (owner == OWN_LSU);

endmodule
